// File: rtl/mlp_pkg.sv
// Shared types and constants for the two-layer MLP sequencer.
// Command codes match what the slp neuron engine decodes.
package mlp_pkg;

  localparam int MLP_ADDR_W = 15;
  localparam int MLP_DATA_W = 8;

  localparam logic [3:0] CMD_NONE   = 4'd0;
  localparam logic [3:0] CMD_HIDDEN = 4'd5;
  localparam logic [3:0] CMD_OUT    = 4'd8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE_H,
    S_WAIT_H,
    S_ISSUE_O,
    S_WAIT_O,
    S_FIN
  } mlp_state_e;

endpackage

// File: rtl/mlp_layer_ctrl.sv
// Sequences hidden and output neuron evaluations on slp,
// writing hidden results back to SPRAM and streaming outputs.
module mlp_layer_ctrl
  import mlp_pkg::*;
#(
  parameter int              ADDR_W  = MLP_ADDR_W,
  parameter int              DATA_W  = MLP_DATA_W,
  parameter int              TO_W    = 16,
  parameter logic [TO_W-1:0] TIMEOUT = 16'hFFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        num_of_vect,
  input  logic [7:0]        num_hidden,
  input  logic [7:0]        num_out,
  input  logic [ADDR_W-1:0] in_base,
  input  logic [ADDR_W-1:0] w_base,
  input  logic [ADDR_W-1:0] hid_base,
  input  logic              neu_done,
  input  logic [DATA_W-1:0] neu_out,
  output logic [3:0]        state,
  output logic [ADDR_W-1:0] inread,
  output logic [ADDR_W-1:0] weightread,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              res_valid,
  output logic [7:0]        res_idx,
  output logic [DATA_W-1:0] res_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  mlp_state_e        st_q, st_d;
  logic [7:0]        k_q, k_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic [7:0]        nov_q, nov_d;
  logic [7:0]        nh_q, nh_d;
  logic [7:0]        no_q, no_d;
  logic [ADDR_W-1:0] inb_q, inb_d;
  logic [ADDR_W-1:0] hidb_q, hidb_d;

  logic [3:0]        cmd_d;
  logic [ADDR_W-1:0] inread_d, weightread_d;
  logic              wr_en_d;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [DATA_W-1:0] wr_data_d;
  logic              res_valid_d;
  logic [7:0]        res_idx_d;
  logic [DATA_W-1:0] res_data_d;
  logic              busy_d, done_d, err_d;

  logic [ADDR_W-1:0] wp_h, wp_o;

  // Weight pointer walks the packed weight block by accumulation.
  assign wp_h = wptr_q + ADDR_W'(nov_q);
  assign wp_o = wptr_q + ADDR_W'(nh_q);

  always_ff @(posedge clk) begin
    if (!reset) begin
      st_q <= S_IDLE;
    end else begin
      st_q <= st_d;
    end
  end

  always_comb begin
    st_d         = st_q;
    k_d          = k_q;
    wptr_d       = wptr_q;
    to_d         = to_q;
    nov_d        = nov_q;
    nh_d         = nh_q;
    no_d         = no_q;
    inb_d        = inb_q;
    hidb_d       = hidb_q;
    cmd_d        = CMD_NONE;
    inread_d     = inread;
    weightread_d = weightread;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr;
    wr_data_d    = wr_data;
    res_valid_d  = 1'b0;
    res_idx_d    = res_idx;
    res_data_d   = res_data;
    done_d       = 1'b0;
    err_d        = err;

    unique case (st_q)
      S_IDLE: begin
        if (start) begin
          nov_d  = num_of_vect;
          nh_d   = num_hidden;
          no_d   = num_out;
          inb_d  = in_base;
          hidb_d = hid_base;
          k_d    = 8'd0;
          wptr_d = w_base;
          err_d  = 1'b0;
          if (num_hidden == 8'd0 || num_out == 8'd0) begin
            err_d = 1'b1;
            st_d  = S_FIN;
          end else begin
            st_d         = S_ISSUE_H;
            cmd_d        = CMD_HIDDEN;
            inread_d     = in_base;
            weightread_d = w_base;
          end
        end
      end
      S_ISSUE_H: begin
        st_d = S_WAIT_H;
        to_d = '0;
      end
      S_WAIT_H: begin
        if (neu_done) begin
          wr_en_d      = 1'b1;
          wr_addr_d    = hidb_q + ADDR_W'(k_q);
          wr_data_d    = neu_out;
          wptr_d       = wp_h;
          weightread_d = wp_h;
          if (k_q == nh_q - 8'd1) begin
            k_d      = 8'd0;
            st_d     = S_ISSUE_O;
            cmd_d    = CMD_OUT;
            inread_d = hidb_q;
          end else begin
            k_d      = k_q + 8'd1;
            st_d     = S_ISSUE_H;
            cmd_d    = CMD_HIDDEN;
            inread_d = inb_q;
          end
        end else if (to_q == TO_LAST) begin
          err_d = 1'b1;
          st_d  = S_FIN;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      S_ISSUE_O: begin
        st_d = S_WAIT_O;
        to_d = '0;
      end
      S_WAIT_O: begin
        if (neu_done) begin
          res_valid_d = 1'b1;
          res_idx_d   = k_q;
          res_data_d  = neu_out;
          wptr_d      = wp_o;
          if (k_q == no_q - 8'd1) begin
            st_d = S_FIN;
          end else begin
            k_d          = k_q + 8'd1;
            st_d         = S_ISSUE_O;
            cmd_d        = CMD_OUT;
            inread_d     = hidb_q;
            weightread_d = wp_o;
          end
        end else if (to_q == TO_LAST) begin
          err_d = 1'b1;
          st_d  = S_FIN;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      S_FIN: begin
        done_d = 1'b1;
        st_d   = S_IDLE;
      end
      default: st_d = S_IDLE;
    endcase

    busy_d = (st_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      k_q        <= '0;
      wptr_q     <= '0;
      to_q       <= '0;
      nov_q      <= '0;
      nh_q       <= '0;
      no_q       <= '0;
      inb_q      <= '0;
      hidb_q     <= '0;
      state      <= CMD_NONE;
      inread     <= '0;
      weightread <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      res_valid  <= 1'b0;
      res_idx    <= '0;
      res_data   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      k_q        <= k_d;
      wptr_q     <= wptr_d;
      to_q       <= to_d;
      nov_q      <= nov_d;
      nh_q       <= nh_d;
      no_q       <= no_d;
      inb_q      <= inb_d;
      hidb_q     <= hidb_d;
      state      <= cmd_d;
      inread     <= inread_d;
      weightread <= weightread_d;
      wr_en      <= wr_en_d;
      wr_addr    <= wr_addr_d;
      wr_data    <= wr_data_d;
      res_valid  <= res_valid_d;
      res_idx    <= res_idx_d;
      res_data   <= res_data_d;
      busy       <= busy_d;
      done       <= done_d;
      err        <= err_d;
    end
  end

endmodule

// File: tb/tb_mlp_layer_ctrl.sv
// Directed bench for mlp_layer_ctrl with a delayed-answer neuron model.
// A second instance with a short watchdog covers the timeout path.
module tb_mlp_layer_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        start2 = 1'b0;
  logic [7:0]  num_of_vect = 8'd3;
  logic [7:0]  num_hidden = 8'd2;
  logic [7:0]  num_out = 8'd1;
  logic [14:0] in_base = 15'h0000;
  logic [14:0] w_base = 15'h0100;
  logic [14:0] hid_base = 15'h0040;
  logic        neu_done = 1'b0;
  logic [7:0]  neu_out = 8'h00;

  logic [3:0]  state;
  logic [14:0] inread, weightread, wr_addr;
  logic        wr_en, res_valid, busy, done, err;
  logic [7:0]  wr_data, res_idx, res_data;

  logic [3:0]  t_state;
  logic [14:0] t_inread, t_weightread, t_wr_addr;
  logic        t_wr_en, t_res_valid, t_busy, t_done, t_err;
  logic [7:0]  t_wr_data, t_res_idx, t_res_data;

  always #5 clk = ~clk;

  mlp_layer_ctrl dut (
    .clk(clk), .reset(reset), .start(start),
    .num_of_vect(num_of_vect), .num_hidden(num_hidden),
    .num_out(num_out), .in_base(in_base), .w_base(w_base),
    .hid_base(hid_base), .neu_done(neu_done), .neu_out(neu_out),
    .state(state), .inread(inread), .weightread(weightread),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .res_valid(res_valid), .res_idx(res_idx),
    .res_data(res_data), .busy(busy), .done(done), .err(err)
  );

  mlp_layer_ctrl #(.TIMEOUT(16'd16)) dut_to (
    .clk(clk), .reset(reset), .start(start2),
    .num_of_vect(num_of_vect), .num_hidden(num_hidden),
    .num_out(num_out), .in_base(in_base), .w_base(w_base),
    .hid_base(hid_base), .neu_done(1'b0), .neu_out(8'h00),
    .state(t_state), .inread(t_inread),
    .weightread(t_weightread), .wr_en(t_wr_en),
    .wr_addr(t_wr_addr), .wr_data(t_wr_data),
    .res_valid(t_res_valid), .res_idx(t_res_idx),
    .res_data(t_res_data), .busy(t_busy), .done(t_done),
    .err(t_err)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Neuron model: answers 20 cycles after an issue.
  bit          spur = 1'b0;
  bit          pend = 1'b0;
  int          cnt = 0;
  logic [7:0]  val = 8'h00;

  always @(negedge clk) begin
    neu_done = 1'b0;
    if (!reset) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          neu_done = 1'b1;
          neu_out  = val;
          pend     = 1'b0;
        end
      end
      if (state != 4'd0) begin
        pend = 1'b1;
        cnt  = 20;
        val  = weightread[7:0] ^ 8'h5A;
        if (spur) begin
          neu_done = 1'b1;
          neu_out  = 8'hEE;
        end
      end
    end
  end

  int          cyc = 0;
  logic [3:0]  iss_cmd[$];
  logic [14:0] iss_in[$], iss_w[$];
  int          iss_cyc[$];
  logic [14:0] wa[$];
  logic [7:0]  wd[$];
  int          wr_cyc[$];
  logic [7:0]  ri[$], rd[$];
  int          res_cyc[$];
  int          n_done = 0;
  int          done_cyc = 0;
  int          n_twr = 0;

  always @(negedge clk) begin
    cyc++;
    if (state != 4'd0) begin
      iss_cmd.push_back(state);
      iss_in.push_back(inread);
      iss_w.push_back(weightread);
      iss_cyc.push_back(cyc);
    end
    if (wr_en) begin
      wa.push_back(wr_addr);
      wd.push_back(wr_data);
      wr_cyc.push_back(cyc);
    end
    if (res_valid) begin
      ri.push_back(res_idx);
      rd.push_back(res_data);
      res_cyc.push_back(cyc);
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (t_wr_en) n_twr++;
  end

  task automatic wait_done(input int lim);
    int i = 0;
    while (!done && i < lim) begin
      @(negedge clk);
      i++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  int bi, bw, br, bd, n;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_state", {28'd0, state}, 32'd0);
    check("rst_inread", {17'd0, inread}, 32'd0);
    check("rst_weightread", {17'd0, weightread}, 32'd0);
    check("rst_wr_en", {31'd0, wr_en}, 32'd0);
    check("rst_wr_addr", {17'd0, wr_addr}, 32'd0);
    check("rst_wr_data", {24'd0, wr_data}, 32'd0);
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_res_idx", {24'd0, res_idx}, 32'd0);
    check("rst_res_data", {24'd0, res_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    reset = 1'b1;

    // Nominal pass
    bi = iss_cmd.size(); bw = wa.size();
    br = ri.size(); bd = n_done;
    pulse_start();
    check("nom_first_cmd", {28'd0, state}, 32'd5);
    check("nom_busy", {31'd0, busy}, 32'd1);
    wait_done(300);
    check("nom_busy_at_done", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("nom_issues", iss_cmd.size() - bi, 32'd3);
    check("nom_i0_cmd", {28'd0, iss_cmd[bi]}, 32'd5);
    check("nom_i0_in", {17'd0, iss_in[bi]}, 32'h0000);
    check("nom_i0_w", {17'd0, iss_w[bi]}, 32'h0100);
    check("nom_i1_cmd", {28'd0, iss_cmd[bi+1]}, 32'd5);
    check("nom_i1_in", {17'd0, iss_in[bi+1]}, 32'h0000);
    check("nom_i1_w", {17'd0, iss_w[bi+1]}, 32'h0103);
    check("nom_i2_cmd", {28'd0, iss_cmd[bi+2]}, 32'd8);
    check("nom_i2_in", {17'd0, iss_in[bi+2]}, 32'h0040);
    check("nom_i2_w", {17'd0, iss_w[bi+2]}, 32'h0106);
    check("nom_writes", wa.size() - bw, 32'd2);
    check("nom_wa0", {17'd0, wa[bw]}, 32'h0040);
    check("nom_wd0", {24'd0, wd[bw]}, 32'h5A);
    check("nom_wa1", {17'd0, wa[bw+1]}, 32'h0041);
    check("nom_wd1", {24'd0, wd[bw+1]}, 32'h59);
    check("nom_b2b", iss_cyc[bi+1], wr_cyc[bw]);
    check("nom_results", ri.size() - br, 32'd1);
    check("nom_res_idx", {24'd0, ri[br]}, 32'd0);
    check("nom_res_data", {24'd0, rd[br]}, 32'h5C);
    check("nom_done_cnt", n_done - bd, 32'd1);
    check("nom_done_lat", done_cyc, res_cyc[br] + 1);
    check("nom_err", {31'd0, err}, 32'd0);

    // Zero hidden count
    bi = iss_cmd.size();
    num_hidden = 8'd0;
    pulse_start();
    check("zero_busy", {31'd0, busy}, 32'd1);
    check("zero_done_early", {31'd0, done}, 32'd0);
    @(negedge clk);
    check("zero_done", {31'd0, done}, 32'd1);
    check("zero_err", {31'd0, err}, 32'd1);
    check("zero_busy_end", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("zero_no_issue", iss_cmd.size() - bi, 32'd0);
    num_hidden = 8'd2;

    // Watchdog timeout on the short-timeout instance
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    check("to_issue", {28'd0, t_state}, 32'd5);
    n = 0;
    while (!t_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("to_latency", n, 32'd18);
    check("to_err", {31'd0, t_err}, 32'd1);
    check("to_busy", {31'd0, t_busy}, 32'd0);
    @(negedge clk);
    check("to_no_write", n_twr, 32'd0);

    // Reset in the second WAIT_H, then rerun
    bd = n_done;
    pulse_start();
    n = 0;
    while (!(state == 4'd5 && weightread == 15'h0103) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rmp_second_issue", {17'd0, weightread}, 32'h0103);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rmp_state", {28'd0, state}, 32'd0);
    check("rmp_busy", {31'd0, busy}, 32'd0);
    check("rmp_weightread", {17'd0, weightread}, 32'd0);
    check("rmp_wr_addr", {17'd0, wr_addr}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    pulse_start();
    check("rmp_re_cmd", {28'd0, state}, 32'd5);
    check("rmp_re_in", {17'd0, inread}, 32'h0000);
    check("rmp_re_w", {17'd0, weightread}, 32'h0100);
    wait_done(300);
    @(negedge clk);
    check("rmp_done_cnt", n_done - bd, 32'd1);

    // start held high, spurious neu_done on each issue
    bi = iss_cmd.size(); bw = wa.size();
    br = ri.size(); bd = n_done;
    spur = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    wait_done(300);
    start = 1'b0;
    spur = 1'b0;
    repeat (3) @(negedge clk);
    check("ign_busy", {31'd0, busy}, 32'd0);
    check("ign_issues", iss_cmd.size() - bi, 32'd3);
    check("ign_writes", wa.size() - bw, 32'd2);
    check("ign_wd0", {24'd0, wd[bw]}, 32'h5A);
    check("ign_wd1", {24'd0, wd[bw+1]}, 32'h59);
    check("ign_results", ri.size() - br, 32'd1);
    check("ign_res_data", {24'd0, rd[br]}, 32'h5C);
    check("ign_done_cnt", n_done - bd, 32'd1);

    // Weight address wrap
    bi = iss_cmd.size();
    w_base = 15'h7FFE;
    pulse_start();
    wait_done(300);
    @(negedge clk);
    check("wrap_issues", iss_cmd.size() - bi, 32'd3);
    check("wrap_w0", {17'd0, iss_w[bi]}, 32'h7FFE);
    check("wrap_w1", {17'd0, iss_w[bi+1]}, 32'h0001);
    check("wrap_w2", {17'd0, iss_w[bi+2]}, 32'h0004);
    check("wrap_err", {31'd0, err}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mlp_layer_ctrl.md
# mlp_layer_ctrl

Upstream sequencer for the single-neuron engine `slp`. On `start` it runs a two-layer MLP pass:
- Hidden layer: issues one neuron evaluation per hidden neuron with state code 5.
- Output layer: issues one evaluation per output neuron with state code 8.
- For every issue it computes the input and weight base addresses into the shared SPRAM, and waits for each neuron result.
- Hidden results are written back into SPRAM as the output layer's input vector. Output-layer results go to the result port.

## Interface
- `ADDR_W`, 15: SPRAM address width, matching `inread`/`weightread`.
- `DATA_W`, 8: neuron output width.
- `TO_W`, 16: width of the per-neuron watchdog counter.
- `TIMEOUT`, 16'hFFFF: cycles allowed in a WAIT state before an error abort.

Ports:
- `clk` in 1: single clock. Rising edge only.
- `reset` in 1: synchronous, active-low reset.
- `start` in 1: level-sampled in IDLE only.
- `num_of_vect` in 8: input vector length.
- `num_hidden` in 8: hidden neuron count.
- `num_out` in 8: output neuron count.
- `in_base` in ADDR_W: SPRAM base address of the network input vector.
- `w_base` in ADDR_W: SPRAM base address of the packed weights (hidden weights first, then output weights).
- `hid_base` in ADDR_W: SPRAM base address where hidden results are stored.
- `neu_done` in 1: one-cycle pulse from the neuron. `neu_out` is valid in the same cycle.
- `neu_out` in DATA_W: neuron tanh result.
- `state` out 4: neuron command. 5 = hidden issue, 8 = output issue, 0 otherwise.
- `inread` out ADDR_W: input base address for the current neuron.
- `weightread` out ADDR_W: weight base address for the current neuron.
- `wr_en` out 1: SPRAM write strobe for hidden results.
- `wr_addr` out ADDR_W: hidden result write address.
- `wr_data` out DATA_W: hidden result write data.
- `res_valid` out 1: one-cycle result strobe.
- `res_idx` out 8: output neuron index of the result.
- `res_data` out DATA_W: output-layer result.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle end-of-pass pulse.
- `err` out 1: sticky error flag, cleared on the next accepted `start`.

`num_of_vect`/`num_hidden` feed `slp` directly at top level. Config inputs must remain stable while `busy`.

## Operation
FSM states: IDLE, ISSUE_H, WAIT_H, ISSUE_O, WAIT_O, FIN.

- **IDLE.**
  - On `start`, latch the configuration, set neuron index k=0, wptr=`w_base`, clear `err`.
  - If `num_hidden`==0 or `num_out`==0: set `err` and go to FIN.
  - Otherwise go to ISSUE_H.
- **ISSUE_H.**
  - Drive `state`=5, `inread`=`in_base`, `weightread`=wptr for exactly one cycle.
  - Go to WAIT_H.
- **WAIT_H.**
  - On `neu_done`, register a write: `wr_addr`=`hid_base`+k, `wr_data`=`neu_out`.
  - Advance wptr += `num_of_vect`.
  - If k==`num_hidden`-1: set k=0 and go to ISSUE_O. Otherwise k++ and go to ISSUE_H.
- **ISSUE_O.**
  - Drive `state`=8, `inread`=`hid_base`, `weightread`=wptr for one cycle.
  - Go to WAIT_O.
- **WAIT_O.**
  - On `neu_done`, register `res_valid`, `res_idx`=k, `res_data`=`neu_out`.
  - Advance wptr += `num_hidden`.
  - On the last output neuron, go to FIN. Otherwise k++ and go to ISSUE_O.
- **FIN.** Pulse `done` and go to IDLE.

Boundary conditions:
- **Watchdog.** The counter clears on entry to WAIT_H/WAIT_O and increments every cycle there. Reaching `TIMEOUT` sets `err` and goes to FIN with no write or result for that neuron.
- **Spurious `neu_done`.** A `neu_done` outside WAIT_H/WAIT_O is ignored.
- **`start` while busy.** Ignored.
- **Same-cycle `neu_done` and timeout.** `neu_done` wins.
- **Address wrap.** All address sums are modulo 2^ADDR_W.
- **Weight pointer.** wptr is an accumulator; no multiplier.

## Timing
- **Reset.** Synchronous, active-low. Every output is 0 after reset: `state`, `inread`, `weightread`, `wr_en`, `wr_addr`, `wr_data`, `res_valid`, `res_idx`, `res_data`, `busy`, `done`, `err`. FSM returns to IDLE.
- **Reset mid-pass.** Abandons the pass immediately. No `done` is generated. The neuron shares `reset`.
- **Start to first issue.** `start` sampled at edge n puts `state`=5 in cycle n+1.
- **Command width.** `state` is nonzero for exactly one cycle per issue. Holding it longer would re-trigger the neuron.
- **Result latency.** `wr_en`/`res_valid` assert the cycle after `neu_done`.
- **Back-to-back issue.** The next ISSUE follows the `neu_done` cycle directly.
- **Pass end.** `done` asserts the cycle after the last result strobe, and `busy` drops in the same cycle as `done`.
- **Outputs.** All outputs are registered.

## Structure
- **`mlp_pkg`.**
  - Command codes `CMD_HIDDEN`=4'd5, `CMD_OUT`=4'd8, `CMD_NONE`=4'd0.
  - FSM state encoding.
  - Default `ADDR_W`/`DATA_W`.
- **No sub-module required.** The watchdog counter stays inline.

## Test plan
- **Nominal pass.** `num_of_vect`=3, `num_hidden`=2, `num_out`=1, `in_base`=0x0000, `w_base`=0x0100, `hid_base`=0x0040, with a neuron model answering after 20 cycles:
  - Issues: (5, 0x0000, 0x0100), (5, 0x0000, 0x0103), (8, 0x0040, 0x0106).
  - Hidden writes to 0x0040 and 0x0041.
  - One `res_valid` with `res_idx`=0.
  - `done` pulses once.
- **Zero count.** `num_hidden`=0 -> no `state` pulse; `err`=1 and `done` two cycles after `start`.
- **Timeout.** Model never answers, `TIMEOUT`=16 -> `err`=1 and `done` after 16 WAIT cycles; no `wr_en`.
- **Reset mid-pass.** `reset` low during the second WAIT_H -> all outputs 0 next cycle. A new `start` then reruns from (5, 0x0000, 0x0100).
- **Ignored inputs.** `start` held high through a whole pass and `neu_done` pulsed during ISSUE_H -> exactly one pass; the spurious pulse causes no write.
- **Address wrap.** `w_base`=0x7FFE, `num_of_vect`=3 -> second hidden `weightread`=0x0001.
